// File: rtl/slope_trigger_pkg.sv
// Shared types and constants for the slope trigger: FSM state encoding,
// timestamp type, drop counter width and the index-width helper.
package slope_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2,
    REARM   = 2'd3
  } state_t;

  localparam int unsigned TIMESTAMP_W = 48;
  typedef logic [TIMESTAMP_W-1:0] timestamp_t;

  localparam int unsigned DROP_W = 16;

  // Width of a sample index within a beat; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_slope_trigger_if.sv
// AXI-stream style handshake bundle; ok marks a completed transfer.
interface Axis_If #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic                  ok;

  assign ok = valid & ready;

  modport master (output data, output valid, output last, input ok);
  modport slave  (input data, input valid, input ok, output ready);
endinterface

// File: rtl/axis_slope_trigger_finder.sv
// Combinational priority search: lowest sample index whose signed value
// reaches the threshold.
module first_crossing_finder #(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned PARALLEL_SAMPLES = 2,
  parameter int unsigned INDEX_WIDTH      = 1
) (
  input  logic [SAMPLE_WIDTH*PARALLEL_SAMPLES-1:0] samples,
  input  logic [SAMPLE_WIDTH-1:0]                  threshold,
  output logic                                     found,
  output logic [INDEX_WIDTH-1:0]                   index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < PARALLEL_SAMPLES; i++) begin
      if (!found && ($signed(samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) >= $signed(threshold))) begin
        found = 1'b1;
        index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/axis_slope_trigger.sv
// Rising-slope trigger on a derivative sample stream; emits sample timestamps.
// Define SLOPE_TRIGGER_HYSTERESIS_EN to require a dip to threshold_low before re-arming.
module axis_slope_trigger
  import slope_trigger_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned PARALLEL_SAMPLES = 2,
  parameter int unsigned TIMESTAMP_WIDTH  = 48,
  parameter int unsigned HOLDOFF_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  Axis_If.slave                    data_in,
  Axis_If.master                   trigger_out,
  input  logic                     enable,
  input  logic [SAMPLE_WIDTH-1:0]  threshold_high,
  input  logic [SAMPLE_WIDTH-1:0]  threshold_low,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_beats,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int unsigned IDX_W = idx_width(PARALLEL_SAMPLES);

  state_t                     state_q;
  logic [TIMESTAMP_WIDTH-1:0] ts_q;
  logic [HOLDOFF_WIDTH-1:0]   hold_cnt_q;
  logic [TIMESTAMP_WIDTH-1:0] out_data_q;
  logic                       out_valid_q;
  logic [DROP_W-1:0]          drop_q;
  logic                       beat;
  logic                       hit;
  logic [IDX_W-1:0]           hit_idx;
  logic                       fire;

  assign data_in.ready    = reset;
  assign beat             = data_in.ok;
  assign trigger_out.data  = out_data_q;
  assign trigger_out.valid = out_valid_q;
  assign trigger_out.last  = 1'b0;
  assign drop_count        = drop_q;

  first_crossing_finder #(
    .SAMPLE_WIDTH    (SAMPLE_WIDTH),
    .PARALLEL_SAMPLES(PARALLEL_SAMPLES),
    .INDEX_WIDTH     (IDX_W)
  ) u_finder (
    .samples  (data_in.data),
    .threshold(threshold_high),
    .found    (hit),
    .index    (hit_idx)
  );

`ifdef SLOPE_TRIGGER_HYSTERESIS_EN
  localparam state_t AFTER_HOLD = REARM;
  logic below_low;

  always_comb begin
    below_low = 1'b0;
    for (int unsigned i = 0; i < PARALLEL_SAMPLES; i++) begin
      if ($signed(data_in.data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]) <= $signed(threshold_low))
        below_low = 1'b1;
    end
  end
`else
  localparam state_t AFTER_HOLD = ARMED;
  logic unused_threshold_low;
  assign unused_threshold_low = ^threshold_low;
`endif

  assign fire = beat && enable && (state_q == ARMED) && hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_q <= '0;
    end else if (beat) begin
      ts_q <= ts_q + TIMESTAMP_WIDTH'(PARALLEL_SAMPLES);
    end
  end

  // A zero holdoff skips HOLDOFF entirely so the very next beat is evaluated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:  state_q <= ARMED;
        ARMED: begin
          if (fire) begin
            if (holdoff_beats == '0) begin
              state_q <= AFTER_HOLD;
            end else begin
              state_q    <= HOLDOFF;
              hold_cnt_q <= holdoff_beats;
            end
          end
        end
        HOLDOFF: begin
          if (beat) begin
            if (hold_cnt_q == HOLDOFF_WIDTH'(1)) state_q <= AFTER_HOLD;
            else                                 hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
`ifdef SLOPE_TRIGGER_HYSTERESIS_EN
        REARM: begin
          if (beat && below_low) state_q <= ARMED;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-entry output register; a new event replaces one leaving this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= '0;
    end else if (fire) begin
      if (!out_valid_q || trigger_out.ok) begin
        out_data_q  <= ts_q + TIMESTAMP_WIDTH'(hit_idx);
        out_valid_q <= 1'b1;
      end else if (drop_q != '1) begin
        drop_q <= drop_q + 1'b1;
      end
    end else if (trigger_out.ok) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_slope_trigger.sv
// Scoreboard bench for axis_slope_trigger: expected timestamps are queued as
// beats are driven and compared when trigger_out completes a transfer.
module tb_axis_slope_trigger;
  import slope_trigger_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] thr_h;
  logic [15:0] thr_l;
  logic [15:0] hold;
  logic [15:0] drop_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  timestamp_t  exp_q[$];

  Axis_If #(.DATA_WIDTH(32)) din  ();
  Axis_If #(.DATA_WIDTH(48)) tout ();

  axis_slope_trigger #(
    .SAMPLE_WIDTH    (16),
    .PARALLEL_SAMPLES(2),
    .TIMESTAMP_WIDTH (48),
    .HOLDOFF_WIDTH   (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (din),
    .trigger_out   (tout),
    .enable        (enable),
    .threshold_high(thr_h),
    .threshold_low (thr_l),
    .holdoff_beats (hold),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int s0, input int s1);
    return {16'(s1), 16'(s0)};
  endfunction

  task automatic send(input logic [31:0] d);
    din.data  = d;
    din.valid = 1'b1;
    @(posedge clk);
    #1;
    din.valid = 1'b0;
  endtask

  task automatic do_reset();
    din.valid = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    din.valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (reset && tout.valid && tout.ready) begin
      if (exp_q.size() == 0) check("sb_spurious", 64'(exp_q.size()), 64'd1);
      else                   check("sb_event", 64'(tout.data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b1; thr_h = 16'd100; thr_l = 16'd20; hold = 16'd3;
    din.valid = 1'b0; din.data = '0; din.last = 1'b0; tout.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(din.ready), 64'd0);
    check("rst_valid", 64'(tout.valid), 64'd0);
    check("rst_data",  64'(tout.data), 64'd0);
    check("rst_drop",  64'(drop_count), 64'd0);
    check("rst_last",  64'(tout.last), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_high", 64'(din.ready), 64'd1);

    // First crossing inside a beat, latency one clock
    do_reset();
    check("s1_pre_valid", 64'(tout.valid), 64'd0);
    exp_q.push_back(1);
    send(pack(50, 150));
    check("s1_lat_valid", 64'(tout.valid), 64'd1);
    check("s1_lat_data",  64'(tout.data), 64'd1);
    drain("s1_drain");

    // Timestamp advances by two per beat
    do_reset();
    exp_q.push_back(10);
    repeat (5) send(pack(0, 0));
    send(pack(200, 200));
    drain("s2_drain");

`ifdef SLOPE_TRIGGER_HYSTERESIS_EN
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(26);
    repeat (12) send(pack(150, 150));
    send(pack(10, 10));
    send(pack(150, 150));
    drain("s3_hyst_drain");

    hold = 16'd0;
    do_reset();
    tout.ready = 1'b0;
    send(pack(150, 150));
    check("s4_data0", 64'(tout.data), 64'd0);
    send(pack(10, 10));
    check("s4_drop_b1", 64'(drop_count), 64'd0);
    send(pack(150, 150));
    check("s4_drop_b2", 64'(drop_count), 64'd1);
    check("s4_data_hold", 64'(tout.data), 64'd0);
    exp_q.push_back(0);
    tout.ready = 1'b1;
    drain("s4_drain");
    hold = 16'd3;
`else
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(8);
    exp_q.push_back(16);
    repeat (12) send(pack(150, 150));
    drain("s3_drain");

    hold = 16'd0;
    do_reset();
    tout.ready = 1'b0;
    send(pack(150, 150));
    check("s4_drop_b0", 64'(drop_count), 64'd0);
    check("s4_valid",   64'(tout.valid), 64'd1);
    send(pack(150, 150));
    check("s4_drop_b1", 64'(drop_count), 64'd1);
    check("s4_data_b1", 64'(tout.data), 64'd0);
    send(pack(150, 150));
    check("s4_drop_b2", 64'(drop_count), 64'd2);
    check("s4_data_b2", 64'(tout.data), 64'd0);
    exp_q.push_back(0);
    tout.ready = 1'b1;
    drain("s4_drain");

    // Pop and new event in the same clock: replace, no drop
    do_reset();
    exp_q.push_back(0);
    exp_q.push_back(2);
    exp_q.push_back(4);
    repeat (3) send(pack(150, 150));
    check("s5_no_drop", 64'(drop_count), 64'd0);
    drain("s5_drain");
    hold = 16'd3;
`endif

    // Disabled beats advance the timestamp but never trigger
    do_reset();
    enable = 1'b0;
    @(posedge clk);
    #1;
    send(pack(150, 150));
    enable = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(3);
    send(pack(50, 150));
    drain("s6_drain");

    // Reset while an event is held and the machine is in holdoff
    do_reset();
    tout.ready = 1'b0;
    send(pack(150, 150));
    send(pack(150, 150));
    reset = 1'b0;
    #1;
    check("s7_rst_valid", 64'(tout.valid), 64'd0);
    check("s7_rst_data",  64'(tout.data), 64'd0);
    check("s7_rst_drop",  64'(drop_count), 64'd0);
    check("s7_rst_ready", 64'(din.ready), 64'd0);
    tout.ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(0);
    send(pack(150, 150));
    check("s7_post_data", 64'(tout.data), 64'd0);
    drain("s7_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_slope_trigger.md
AXIS_SLOPE_TRIGGER -- requirements
Module: axis_slope_trigger

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per signed derivative sample.
REQ-002 SHALL have parameter PARALLEL_SAMPLES, default 2, samples per beat; index 0 is the oldest and occupies the LSBs.
REQ-003 SHALL have parameter TIMESTAMP_WIDTH, default 48, width of the sample-index counter.
REQ-004 SHALL have parameter HOLDOFF_WIDTH, default 16, width of the holdoff_beats input.
REQ-005 clk  input  1  sole clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 data_in  Axis_If slave  SAMPLE_WIDTH*PARALLEL_SAMPLES  derivative samples from axis_differentiator.
REQ-008 trigger_out  Axis_If master  TIMESTAMP_WIDTH  timestamp of each trigger event.
REQ-009 enable  input  1  arms the trigger when high.
REQ-010 threshold_high  input  SAMPLE_WIDTH  signed rising-slope trigger level.
REQ-011 threshold_low  input  SAMPLE_WIDTH  signed re-arm level.
REQ-012 holdoff_beats  input  HOLDOFF_WIDTH  number of accepted beats ignored after each trigger.
REQ-013 drop_count  output  16  saturating count of events lost to backpressure.

Function
REQ-014 data_in.ready SHALL be constantly 1 outside reset, so the block never stalls upstream.
REQ-015 The timestamp counter SHALL add PARALLEL_SAMPLES on every accepted beat (data_in.ok), wrap modulo 2^TIMESTAMP_WIDTH, and count regardless of enable.
REQ-016 The state machine SHALL have four states, IDLE, ARMED, HOLDOFF and REARM, and SHALL advance only on accepted beats, except IDLE-to-ARMED, which occurs on the first clock with enable high.
REQ-017 In ARMED, on each beat the module SHALL find the lowest index i with sample[i] >= threshold_high (signed compare); if one exists it SHALL emit timestamp_of_beat+i and go to HOLDOFF.
REQ-018 At most one event SHALL be emitted per beat; samples after index i in that beat are ignored.
REQ-019 HOLDOFF SHALL consume holdoff_beats accepted beats and then go to REARM; holdoff_beats=0 SHALL go to REARM on the first beat after the trigger.
REQ-020 In REARM, a beat with any sample <= threshold_low SHALL return the machine to ARMED; that beat itself SHALL NOT trigger.
REQ-021 enable low SHALL force IDLE on the next clock from any state, and an event already held in the output register SHALL be kept.
REQ-022 An event SHALL appear on trigger_out.valid exactly one clock after its data_in beat is accepted (latency 1).
REQ-023 The output SHALL be a one-entry register that holds data and valid stable until trigger_out.ok.
REQ-024 If a new event arrives while the output register is full and trigger_out.ready is 0, the new event SHALL be discarded and drop_count incremented, saturating at 16'hFFFF.
REQ-025 If trigger_out.ok and a new event occur in the same clock, the register SHALL load the new event and no drop SHALL be counted.
REQ-026 trigger_out.last SHALL be tied to 0.

Reset
REQ-027 While reset=0: state=IDLE, timestamp=0, trigger_out.valid=0, trigger_out.data=0, drop_count=0, data_in.ready=0.
REQ-028 Reset asserted mid-HOLDOFF or mid-REARM SHALL discard the pending event and holdoff progress; after reset deassertion the machine SHALL re-enter ARMED only through REQ-016.

Configuration
REQ-029 With SLOPE_TRIGGER_HYSTERESIS_EN defined, REARM SHALL behave per REQ-020.
REQ-030 Without SLOPE_TRIGGER_HYSTERESIS_EN, HOLDOFF SHALL go directly to ARMED, REARM SHALL not exist, and threshold_low SHALL be ignored.

Structure
REQ-031 The state enum, timestamp typedef and drop-counter width constant SHALL reside in the shared package slope_trigger_pkg.
REQ-032 The first-crossing priority search SHALL be the sub-module first_crossing_finder (combinational, returns a found flag and an index).

Verification
(All scenarios use threshold_high=100, threshold_low=20, holdoff_beats=3, enable=1, trigger_out.ready=1 unless stated.)
REQ-033 Beat 0 = {50,150} -> one event with data=1, valid exactly one clock after acceptance.
REQ-034 Beats 0-4 = {0,0}, beat 5 = {200,200} -> a single event with data=10.
REQ-035 HYSTERESIS_EN defined, 12 beats of {150,150}, then {10,10}, then {150,150} -> events at timestamps 0 and 26 only.
REQ-036 HYSTERESIS_EN undefined, 12 beats of {150,150} -> events at timestamps 0, 8 and 16.
REQ-037 trigger_out.ready=0, holdoff_beats=0, no hysteresis, 3 beats of {150,150} -> output holds data=0; drop_count=1 after beat 1 and 2 after beat 2.
REQ-038 Reset pulsed during HOLDOFF -> all outputs zero, timestamp restarts at 0, and the next {150,150} beat triggers with data=0.
